// File: rtl/onewire_seq.sv
// onewire_seq: byte-level command sequencer in front of the onewire master.
//
// The host sends reset / write-byte / read-byte / CRC-clear commands. Each
// command is broken into bit slots. For every slot the sequencer writes the
// master's control register once, then polls its status register until the
// slot completes. Presence, the received byte and timeout status come back
// on the response channel.
//
// Ports:
//   clk, rst            clock; asynchronous reset, active-low
//   cmd_valid/ready     command handshake; cmd_op selects the operation,
//                       cmd_data is the byte to write
//   rsp_valid/ready     response handshake; rsp_data, rsp_presence and
//                       rsp_error are held until the response is accepted
//   busy                command in progress or response pending
//   m_read/m_write      Avalon MM master toward the onewire master
//   m_writedata,
//   m_readdata,
//   m_waitrequest
//   crc                 running Dallas CRC8
//
// Build option: define ONEWIRE_SEQ_CRC_EN to enable the CRC8 accumulator.
// Without it, crc is tied to zero and op 11 only returns an empty response.

module onewire_seq #(
    parameter int ADW = 32,
    parameter int PDL = 8,
    parameter int TMO = 4096,
    parameter int TCW = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_op,
    input  logic [7:0]     cmd_data,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [7:0]     rsp_data,
    output logic           rsp_presence,
    output logic           rsp_error,
    output logic           busy,
    output logic           m_read,
    output logic           m_write,
    output logic [ADW-1:0] m_writedata,
    input  logic [ADW-1:0] m_readdata,
    input  logic           m_waitrequest,
    output logic [7:0]     crc
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_DELAY = 3'd2;
    localparam logic [2:0] S_POLL  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam logic [1:0] OP_RST = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_CRC = 2'b11;

    localparam int DW = (PDL > 1) ? $clog2(PDL) : 1;
    localparam logic [DW-1:0]  DLY_LAST = DW'(PDL - 1);
    localparam logic [TCW-1:0] TMO_C    = TCW'(TMO);

    logic [2:0]     state;
    logic [1:0]     op_r;
    logic [7:0]     byte_r;
    logic [2:0]     bit_cnt;
    logic [TCW-1:0] poll_cnt;
    logic [TCW-1:0] poll_inc;
    logic [DW-1:0]  dly_cnt;
    logic           sample;

    assign poll_inc = poll_cnt + 1'b1;

    // Avalon strobes are decoded from the state, so an asynchronous reset
    // drops any in-flight transfer immediately. Address/data stay stable
    // because op_r, byte_r and bit_cnt do not change inside ISSUE/POLL.
    assign m_write   = (state == S_ISSUE);
    assign m_read    = (state == S_POLL);
    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    always_comb begin
        m_writedata = '0;
        if (state == S_ISSUE) begin
            case (op_r)
                OP_RST:  m_writedata[1] = 1'b1;
                OP_WR:   m_writedata[0] = byte_r[bit_cnt];
                default: m_writedata[0] = 1'b1;   // read slot releases the line
            endcase
        end
    end

`ifdef ONEWIRE_SEQ_CRC_EN
    logic [7:0] crc_r;

    // Dallas/Maxim CRC8, reflected form of x^8+x^5+x^4+1, one bit per call.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        crc8_step = {1'b0, c[7:1]} ^ (fb ? 8'h8C : 8'h00);
    endfunction

    assign crc = crc_r;
`else
    assign crc = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            op_r         <= 2'b00;
            byte_r       <= 8'h00;
            bit_cnt      <= 3'd0;
            poll_cnt     <= '0;
            dly_cnt      <= '0;
            sample       <= 1'b0;
            rsp_data     <= 8'h00;
            rsp_presence <= 1'b0;
            rsp_error    <= 1'b0;
`ifdef ONEWIRE_SEQ_CRC_EN
            crc_r        <= 8'h00;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_r         <= cmd_op;
                        byte_r       <= cmd_data;
                        bit_cnt      <= 3'd0;
                        poll_cnt     <= '0;
                        rsp_data     <= 8'h00;
                        rsp_presence <= 1'b0;
                        rsp_error    <= 1'b0;
                        if (cmd_op == OP_CRC) begin
`ifdef ONEWIRE_SEQ_CRC_EN
                            crc_r <= 8'h00;
`endif
                            state <= S_RESP;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    if (!m_waitrequest) begin
                        dly_cnt <= '0;
                        state   <= S_DELAY;
                    end
                end

                S_DELAY: begin
                    if (dly_cnt == DLY_LAST) begin
                        state <= S_POLL;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end

                S_POLL: begin
                    if (!m_waitrequest) begin
                        if (m_readdata[4]) begin
                            sample <= m_readdata[0];
                            state  <= S_NEXT;
                        end else if (poll_inc == TMO_C) begin
                            // Timeout aborts the remaining bits; rsp_data keeps
                            // whatever has been shifted in so far.
                            poll_cnt  <= poll_inc;
                            rsp_error <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            poll_cnt <= poll_inc;
                            dly_cnt  <= '0;
                            state    <= S_DELAY;
                        end
                    end
                end

                S_NEXT: begin
                    if (op_r == OP_RST) begin
                        // A slave pulls the line low during the presence window.
                        rsp_presence <= ~sample;
                        state        <= S_RESP;
                    end else begin
                        // Bytes go LSB-first on the wire, so shift right into bit 7.
                        rsp_data <= {sample, rsp_data[7:1]};
`ifdef ONEWIRE_SEQ_CRC_EN
                        crc_r    <= crc8_step(crc_r, sample);
`endif
                        if (bit_cnt == 3'd7) begin
                            state <= S_RESP;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            poll_cnt <= '0;
                            state    <= S_ISSUE;
                        end
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_onewire_seq.sv
// Testbench for onewire_seq. Stimulus pushes expected responses and expected
// Avalon writes into queues; a monitor process compares them as the DUT
// produces them. A small onewire-master model answers the Avalon port.

module tb_onewire_seq;

    localparam int ADW = 32;
    localparam int PDL = 2;
    localparam int TMO = 4;
    localparam int TCW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_op = 2'b00;
    logic [7:0]     cmd_data = 8'h00;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [7:0]     rsp_data;
    logic           rsp_presence;
    logic           rsp_error;
    logic           busy;
    logic           m_read;
    logic           m_write;
    logic [ADW-1:0] m_writedata;
    logic [ADW-1:0] m_readdata;
    logic           m_waitrequest;
    logic [7:0]     crc;

    always #5 clk = ~clk;

    onewire_seq #(.ADW(ADW), .PDL(PDL), .TMO(TMO), .TCW(TCW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_presence(rsp_presence), .rsp_error(rsp_error), .busy(busy),
        .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest), .crc(crc)
    );

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       pres;
        logic       err;
        int         nwr;
        int         nrd;
    } exp_t;

    exp_t        sq[$];
    logic [31:0] wq[$];
    int n_chk = 0;
    int n_fail = 0;

    // Slave model knobs, written only by the stimulus process.
    int         wait_cycles = 0;
    int         polls_needed = 2;
    int         to_bit = 99;
    int         rd_mode = 0;
    int         slave_present = 1;
    int         rsp_delay = 0;
    logic [7:0] rd_byte = 8'h00;

    // Slave model state.
    int   wcnt;
    int   pc;
    int   bidx;
    logic sample_m;
    logic done;

    // Monitor counters of completed transfers for the current command.
    int nwr = 0;
    int nrd = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    assign m_waitrequest = (m_read | m_write) && (wcnt < wait_cycles);
    assign done          = (bidx <= to_bit) && (pc >= polls_needed - 1);
    assign m_readdata    = {27'd0, done, 3'd0, sample_m};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt     <= 0;
            pc       <= 0;
            bidx     <= 0;
            sample_m <= 1'b1;
        end else begin
            if ((m_read | m_write) && m_waitrequest) wcnt <= wcnt + 1;
            else wcnt <= 0;
            if (m_write && !m_waitrequest) begin
                pc <= 0;
                if (m_writedata[1]) sample_m <= (slave_present == 0);
                else if (m_writedata[0]) begin
                    sample_m <= (rd_mode != 0) ? rd_byte[bidx & 7] : 1'b1;
                    bidx     <= bidx + 1;
                end else sample_m <= 1'b0;
            end
            if (m_read && !m_waitrequest) pc <= pc + 1;
            if (rsp_valid && rsp_ready) bidx <= 0;
        end
    end

    // Monitor: Avalon writes, stall stability, response hold and response check.
    initial begin
        logic        hold;
        int          hcnt;
        logic [7:0]  h_data;
        logic        h_p, h_e;
        logic        prev_stall, pr, pw;
        logic [31:0] pwd;
        exp_t        e;
        hold = 0; hcnt = 0; prev_stall = 0; pr = 0; pw = 0; pwd = 0;
        h_data = 0; h_p = 0; h_e = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                wq.delete(); sq.delete();
                nwr = 0; nrd = 0; rsp_ready = 1'b0;
                hold = 0; hcnt = 0; prev_stall = 0;
                continue;
            end
            if (prev_stall) begin
                chk("stall_read", m_read, pr);
                chk("stall_write", m_write, pw);
                chk("stall_wdata", m_writedata, pwd);
            end
            prev_stall = (m_read | m_write) && m_waitrequest;
            pr = m_read; pw = m_write; pwd = m_writedata;
            if (m_read | m_write) chk("one_strobe", m_read & m_write, 0);
            if (m_write && !m_waitrequest) begin
                nwr++;
                if (wq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL wr_unexpected: got 0x%0h, expected no write", m_writedata);
                end else chk("wr_data", m_writedata, wq.pop_front());
            end
            if (m_read && !m_waitrequest) nrd++;

            if (rsp_ready) rsp_ready = 1'b0;
            else if (rsp_valid) begin
                if (!hold) begin
                    hold = 1; hcnt = 0;
                    h_data = rsp_data; h_p = rsp_presence; h_e = rsp_error;
                end else begin
                    chk("hold_data", rsp_data, h_data);
                    chk("hold_pres", rsp_presence, h_p);
                    chk("hold_err", rsp_error, h_e);
                end
                if (hcnt >= rsp_delay) begin
                    if (sq.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL rsp_unexpected: got data 0x%0h, expected no response", rsp_data);
                    end else begin
                        e = sq.pop_front();
                        chk({e.name, "_data"}, rsp_data, e.data);
                        chk({e.name, "_pres"}, rsp_presence, e.pres);
                        chk({e.name, "_err"}, rsp_error, e.err);
                        chk({e.name, "_nwr"}, nwr, e.nwr);
                        chk({e.name, "_nrd"}, nrd, e.nrd);
                    end
                    nwr = 0; nrd = 0;
                    rsp_ready = 1'b1;
                    hold = 0;
                end else hcnt++;
            end
        end
    end

    task automatic push_rsp(input string nm, input logic [7:0] d, input logic p,
                            input logic er, input int w, input int r);
        exp_t e;
        e.name = nm; e.data = d; e.pres = p; e.err = er; e.nwr = w; e.nrd = r;
        sq.push_back(e);
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d);
        bit ok;
        ok = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        for (int k = 0; k < 1000; k++) begin
            if (cmd_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL cmd_accept: got cmd_ready=0, expected 1 within budget");
        end
    endtask

    task automatic drain(input string nm);
        bit ok;
        ok = 0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (sq.size() == 0 && !busy && !rsp_ready) begin
                ok = 1;
                break;
            end
        end
        chk({nm, "_done"}, ok, 1);
        chk({nm, "_wq_empty"}, wq.size(), 0);
    endtask

    task automatic wr_byte(input string nm, input logic [7:0] d, input int rpb);
        for (int i = 0; i < 8; i++) wq.push_back({31'd0, d[i]});
        push_rsp(nm, d, 1'b0, 1'b0, 8, 8 * rpb);
        send(2'b01, d);
        drain(nm);
    endtask

    task automatic rd_byte_cmd(input string nm, input logic [7:0] d, input int rpb);
        rd_mode = 1; rd_byte = d;
        for (int i = 0; i < 8; i++) wq.push_back(32'h1);
        push_rsp(nm, d, 1'b0, 1'b0, 8, 8 * rpb);
        send(2'b10, 8'h00);
        drain(nm);
        rd_mode = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_write", m_write, 0);
        chk("rst_m_read", m_read, 0);
        chk("rst_wdata", m_writedata, 0);
        chk("rst_crc", crc, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // Reset/presence, slave present then absent
        slave_present = 1;
        wq.push_back(32'h2);
        push_rsp("pres1", 8'h00, 1'b1, 1'b0, 1, 2);
        send(2'b00, 8'h77);
        drain("pres1");
        slave_present = 0;
        wq.push_back(32'h2);
        push_rsp("pres0", 8'h00, 1'b0, 1'b0, 1, 2);
        send(2'b00, 8'h00);
        drain("pres0");
        slave_present = 1;

        // Write and read bytes
        wr_byte("wrA5", 8'hA5, 2);
        rd_byte_cmd("rd3C", 8'h3C, 2);

        // Wait states on every transfer, response accepted late
        wait_cycles = 5; rsp_delay = 3; polls_needed = 1;
        rd_byte_cmd("rd96w", 8'h96, 1);
        wr_byte("wr5Aw", 8'h5A, 1);
        wait_cycles = 0; rsp_delay = 0; polls_needed = 2;

        // Timeout on the first slot: exactly TMO polls
        to_bit = 0; rd_mode = 1; rd_byte = 8'hFF;
        wq.push_back(32'h1);
        push_rsp("tmo0", 8'h00, 1'b0, 1'b1, 1, 4);
        send(2'b10, 8'h00);
        drain("tmo0");

        // Timeout on the fourth slot: three bits already shifted in
        to_bit = 3;
        for (int i = 0; i < 4; i++) wq.push_back(32'h1);
        push_rsp("tmo3", 8'hE0, 1'b0, 1'b1, 4, 10);
        send(2'b10, 8'h00);
        drain("tmo3");
        to_bit = 99; rd_mode = 0;

        // Next command after a timeout is accepted normally
        wq.push_back(32'h2);
        push_rsp("pres_after", 8'h00, 1'b1, 1'b0, 1, 2);
        send(2'b00, 8'h00);
        drain("pres_after");

        // Reset in the middle of a byte (during bit 3)
        for (int i = 0; i < 8; i++) wq.push_back({31'd0, 8'hC3 >> i} & 32'h1);
        push_rsp("wrC3", 8'hC3, 1'b0, 1'b0, 8, 16);
        send(2'b01, 8'hC3);
        begin
            bit seen;
            seen = 0;
            for (int k = 0; k < 5000; k++) begin
                @(negedge clk);
                if (nwr >= 3) begin
                    seen = 1;
                    break;
                end
            end
            chk("midrst_reach_bit3", seen, 1);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_m_write", m_write, 0);
        chk("midrst_m_read", m_read, 0);
        chk("midrst_wdata", m_writedata, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_rsp_data", rsp_data, 0);
        chk("midrst_crc", crc, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("postrst_cmd_ready", cmd_ready, 1);
        wr_byte("wr3C_after", 8'h3C, 2);

`ifdef ONEWIRE_SEQ_CRC_EN
        // CRC over the classic ROM example, then the CRC byte itself
        polls_needed = 1;
        push_rsp("crcclr", 8'h00, 1'b0, 1'b0, 0, 0);
        send(2'b11, 8'h00);
        drain("crcclr");
        chk("crc_cleared", crc, 8'h00);
        wr_byte("c02", 8'h02, 1);
        wr_byte("c1C", 8'h1C, 1);
        wr_byte("cB8", 8'hB8, 1);
        wr_byte("c01", 8'h01, 1);
        wr_byte("c00a", 8'h00, 1);
        wr_byte("c00b", 8'h00, 1);
        wr_byte("c00c", 8'h00, 1);
        chk("crc_rom", crc, 8'hA2);
        wr_byte("cA2", 8'hA2, 1);
        chk("crc_zero", crc, 8'h00);
`else
        push_rsp("op11", 8'h00, 1'b0, 1'b0, 0, 0);
        send(2'b11, 8'h00);
        drain("op11");
        chk("crc_off", crc, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
